// File: rtl/apb_param_regfile.sv
// ---------------------------------------------------------------------------
// apb_param_regfile
//   Parametrised APB slave register bank. Each of the NUM_REGS registers has
//   its own access type (RW, RO, W1C, W1S, W1P, WO), a hardware update port
//   and byte-strobe handling. A two-key unlock FSM guards the registers
//   selected by LOCK_MASK. The bank inserts WAIT_STATES extra access cycles,
//   reports errors on PSLVERR, drives one-cycle W1P pulses and raises a
//   registered irq while any W1C bit is set.
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     paddr, psel, penable, pwrite, pwdata, pstrb   APB request
//     prdata, pready, pslverr                       APB response
//     hw_in, hw_we      per-register hardware data / write-set enable
//     reg_out           current register contents, reg i = slice i
//     pulse_out         W1P pulses, reg i = slice i
//     unlocked          unlock FSM is in UNLOCKED
//     irq               registered OR of every W1C register bit
//     lock_state_o      debug view of the unlock FSM state
//
//   Handshake: a transfer is in its access phase while psel & penable. The
//   slave holds pready low for WAIT_STATES cycles, then raises it for one
//   cycle; prdata/pslverr are only meaningful in that cycle, and write side
//   effects land on the clock edge that ends it.
// ---------------------------------------------------------------------------
module apb_param_regfile #(
  parameter int                               DATA_WIDTH  = 32,
  parameter int                               ADDR_WIDTH  = 8,
  parameter int                               NUM_REGS    = 8,
  parameter logic [3*NUM_REGS-1:0]            REG_TYPES   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VALS  = '0,
  parameter logic [NUM_REGS-1:0]              LOCK_MASK   = '0,
  parameter logic [DATA_WIDTH-1:0]            KEY1        = DATA_WIDTH'(32'hA5A5_0001),
  parameter logic [DATA_WIDTH-1:0]            KEY2        = DATA_WIDTH'(32'h5A5A_0002),
  parameter int                               WAIT_STATES = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  input  logic [NUM_REGS-1:0]            hw_we,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS*DATA_WIDTH-1:0] pulse_out,
  output logic                           unlocked,
  output logic                           irq,
  output logic [1:0]                     lock_state_o
);

  localparam int                    DW       = DATA_WIDTH;
  localparam int                    NB       = DATA_WIDTH / 8;
  localparam int                    IDX_W    = ADDR_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] KEY_ADDR = ADDR_WIDTH'(4 * NUM_REGS);

  localparam logic [2:0] T_RW  = 3'd0;
  localparam logic [2:0] T_RO  = 3'd1;
  localparam logic [2:0] T_W1C = 3'd2;
  localparam logic [2:0] T_W1S = 3'd3;
  localparam logic [2:0] T_W1P = 3'd4;
  localparam logic [2:0] T_WO  = 3'd5;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_KEY1_OK  = 2'd1,
    ST_UNLOCKED = 2'd2
  } lock_state_e;

  lock_state_e lock_state_q, lock_state_d;

  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             access;
  logic             aligned;
  logic [IDX_W-1:0] idx;
  logic             reg_hit;
  logic             key_hit;
  logic [2:0]       sel_type;
  logic             sel_lock;
  logic [DW-1:0]    sel_val;
  logic [DW-1:0]    rd_val;
  logic             err;
  logic             commit_ok;
  logic             key_wr;
  logic [DW-1:0]    wmask;
  logic             irq_q, irq_d;

  // ------------------------------------------------------------------
  // Wait-state counter and handshake
  // ------------------------------------------------------------------
  assign access = psel & penable;
  // Gated by rst_n so an in-flight access cannot complete while in reset.
  assign pready = rst_n & access & (wait_cnt_q == 4'(WAIT_STATES));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!psel || pready) begin
      wait_cnt_d = '0;
    end else if (access) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  assign aligned = (paddr[1:0] == 2'b00);
  assign idx     = paddr[ADDR_WIDTH-1:2];
  assign reg_hit = aligned && (paddr < KEY_ADDR);
  assign key_hit = (paddr == KEY_ADDR);

  // Loop-select keeps out-of-range addresses from indexing past the bank.
  always_comb begin
    sel_type = T_RW;
    sel_lock = 1'b0;
    sel_val  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_hit && (idx == IDX_W'(i))) begin
        sel_type = REG_TYPES[3*i +: 3];
        sel_lock = LOCK_MASK[i];
        sel_val  = reg_out[i*DW +: DW];
      end
    end
  end

  assign err = !aligned
            || (paddr > KEY_ADDR)
            || (pwrite && reg_hit &&
                ((sel_type == T_RO) || (sel_lock && (lock_state_q != ST_UNLOCKED))));

  always_comb begin
    rd_val = '0;
    if (reg_hit && ((sel_type == T_RW) || (sel_type == T_RO) ||
                    (sel_type == T_W1C) || (sel_type == T_W1S))) begin
      rd_val = sel_val;
    end
  end

  assign pslverr   = pready & err;
  assign prdata    = (pready && !pwrite && !err) ? rd_val : '0;
  assign commit_ok = pready & pwrite & !err;
  assign key_wr    = commit_ok & key_hit;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++) begin
      wmask[8*b +: 8] = {8{pstrb[b]}};
    end
  end

  // ------------------------------------------------------------------
  // Register bank: one slice per register, behaviour fixed by its type
  // ------------------------------------------------------------------
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    localparam logic [2:0]    TYPE  = REG_TYPES[3*g +: 3];
    localparam logic [DW-1:0] RST_V = (TYPE == T_W1P) ? '0 : RESET_VALS[g*DW +: DW];

    logic          sw_we;
    logic [DW-1:0] hw_v;
    logic [DW-1:0] val_q, val_d;
    logic [DW-1:0] pulse_q, pulse_d;

    assign sw_we = commit_ok && reg_hit && (idx == IDX_W'(g));
    assign hw_v  = hw_in[g*DW +: DW];

    always_comb begin
      val_d   = val_q;
      pulse_d = '0;
      case (TYPE)
        T_RW, T_WO: begin
          if (hw_we[g]) val_d = hw_v;
          // Software write overrides the hardware value in strobed lanes.
          if (sw_we)    val_d = (val_d & ~wmask) | (pwdata & wmask);
        end
        T_RO: begin
          if (hw_we[g]) val_d = hw_v;
        end
        T_W1C: begin
          if (sw_we)    val_d = val_q & ~(pwdata & wmask);
          // Hardware set applied last so a coincident clear never loses it.
          if (hw_we[g]) val_d = val_d | hw_v;
        end
        T_W1S: begin
          if (sw_we)    val_d = val_d | (pwdata & wmask);
          if (hw_we[g]) val_d = val_d | hw_v;
        end
        T_W1P: begin
          val_d = '0;
          if (sw_we) pulse_d = pwdata & wmask;
        end
        default: val_d = val_q;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        val_q   <= RST_V;
        pulse_q <= '0;
      end else begin
        val_q   <= val_d;
        pulse_q <= pulse_d;
      end
    end

    assign reg_out[g*DW +: DW]   = val_q;
    assign pulse_out[g*DW +: DW] = pulse_q;
  end

  // ------------------------------------------------------------------
  // irq: registered OR of every W1C register
  // ------------------------------------------------------------------
  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (REG_TYPES[3*i +: 3] == T_W1C) begin
        irq_d = irq_d | (|reg_out[i*DW +: DW]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

  // ------------------------------------------------------------------
  // Unlock FSM: advances only on error-free committed writes. Key words
  // are compared over the full bus regardless of pstrb.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state_q <= ST_LOCKED;
    end else begin
      lock_state_q <= lock_state_d;
    end
  end

  always_comb begin
    lock_state_d = lock_state_q;
    case (lock_state_q)
      ST_LOCKED: begin
        if (key_wr && (pwdata == KEY1)) lock_state_d = ST_KEY1_OK;
      end
      ST_KEY1_OK: begin
        if (key_wr && (pwdata == KEY2)) lock_state_d = ST_UNLOCKED;
        else if (commit_ok)             lock_state_d = ST_LOCKED;
      end
      ST_UNLOCKED: begin
        if (key_wr) lock_state_d = ST_LOCKED;
      end
      default: lock_state_d = ST_LOCKED;
    endcase
  end

  always_comb begin
    unlocked     = (lock_state_q == ST_UNLOCKED);
    lock_state_o = lock_state_q;
  end

endmodule
